seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter HALT_ON_WRAP, default 0, when 1 the PC wrapping from all-ones to 0 forces HALTED.
REQ-003 clk  input  1  single clock; every state element samples on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 start  input  1  one-cycle pulse; begins execution at address 0 from IDLE or HALTED.
REQ-006 imem_addr  output  ADDR_W  program-memory address (the PC).
REQ-007 imem_data  input  12  instruction word {opcode[11:8], literal[7:0]}; valid one cycle after imem_addr.
REQ-008 inst  output  4  ALU opcode.
REQ-009 b  output  8  ALU operand (the literal).
REQ-010 ans  input  9  combinational ALU result; ans[8] is carry-out.
REQ-011 d  output  1  W-register load strobe, one cycle wide.
REQ-012 busy  output  1  high in any state other than IDLE or HALTED.
REQ-013 halted  output  1  high in HALTED.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, WB and HALTED.
REQ-015 IDLE/HALTED -> FETCH on start; the PC SHALL be cleared to 0 on that same edge.
REQ-016 FETCH: drive imem_addr = PC -> DECODE.
REQ-017 DECODE: latch imem_data into the 12-bit IR -> EXEC.
REQ-018 EXEC/WB: inst = IR[11:8] and b = IR[7:0], both held stable for both cycles; otherwise inst = 0 and b = 0.
REQ-019 ALU opcodes 0-10: EXEC -> WB; in WB, d = 1, Z <= (ans[7:0] == 0), C <= ans[8], PC <= PC+1, then -> FETCH.
REQ-020 Opcode 11 (JMP): in EXEC, PC <= literal[ADDR_W-1:0] -> FETCH; d stays 0 and the flags are unchanged.
REQ-021 Opcode 12 (JZ) and opcode 13 (JC): in EXEC, PC <= literal if the Z flag (JZ) or the C flag (JC) is set, else PC+1; then -> FETCH.
REQ-022 Opcode 14 (NOP): in EXEC, PC <= PC+1 -> FETCH.
REQ-023 Opcode 15 (HALT): in EXEC -> HALTED; the PC is not incremented.
REQ-024 Throughput: an ALU op SHALL take 4 cycles and a control op 3 cycles; no pipelining.
REQ-025 The PC SHALL wrap from 2^ADDR_W-1 to 0; if HALT_ON_WRAP=1, the wrap SHALL enter HALTED instead of FETCH.
REQ-026 start is ignored while busy; start in the same cycle as a HALT in EXEC SHALL still enter HALTED.
REQ-027 d SHALL never be asserted outside WB.

Reset
REQ-028 reset = 0 SHALL immediately force: state IDLE, PC 0, IR 0, Z 0, C 0, d 0, inst 0, b 0, busy 0, halted 0.
REQ-029 Reset asserted mid-instruction SHALL abort that instruction with no d pulse; after release the block waits in IDLE for start.

Configuration
REQ-030 With SEQ_CTRL_BRANCH_EN defined, JZ and JC SHALL behave as in REQ-021.
REQ-031 Without SEQ_CTRL_BRANCH_EN: JZ and JC SHALL act as NOP, and the Z and C flag registers SHALL be absent; JMP is unaffected.

Structure
REQ-032 Package seq_ctrl_pkg SHALL hold:
- the state enum;
- the opcode constants (OP_JMP=11, OP_JZ=12, OP_JC=13, OP_NOP=14, OP_HALT=15, OP_ALU_MAX=10);
- IR_W=12.
REQ-033 Sub-module seq_pc SHALL hold the PC register, with clear, load and increment (priority clear > load > increment) and a wrap flag output.

Verification
REQ-034 Program {0x00A, 0x103, 0xF00}, start pulse -> d pulses in cycles 4 and 8 with b=10 then b=3, halted=1 after cycle 11, imem_addr=2.
REQ-035 Program {0xB05, ..., addr5: 0xF00} -> imem_addr sequence 0,5; d never asserted.
REQ-036 ALU op with ans=9'h100, then 0xD07 -> C=1 and Z=1, jump to address 7; with ans=9'h001 instead -> fall through to PC+1 (JC not taken).
REQ-037 Without SEQ_CTRL_BRANCH_EN: 0xC07 -> PC+1 regardless of the flags.
REQ-038 Reset asserted in WB -> d drops asynchronously, state IDLE; a start after release fetches from address 0.
REQ-039 ADDR_W=2, HALT_ON_WRAP=1, four NOPs -> halted=1 after the wrap to 0; with HALT_ON_WRAP=0 -> execution continues at address 0.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - states, opcodes and widths shared by seq_ctrl and its sub-modules
package seq_ctrl_pkg;

    localparam int IR_W = 12;

    localparam logic [3:0] OP_ALU_MAX = 4'd10;
    localparam logic [3:0] OP_JMP     = 4'd11;
    localparam logic [3:0] OP_JZ      = 4'd12;
    localparam logic [3:0] OP_JC      = 4'd13;
    localparam logic [3:0] OP_NOP     = 4'd14;
    localparam logic [3:0] OP_HALT    = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALTED
    } state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return op <= OP_ALU_MAX;
    endfunction

endpackage

// File: rtl/seq_pc.sv
// rtl/seq_pc.sv - program counter with clear > load > increment priority and wrap flag
module seq_pc #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              wrap
);

    // Combinational: lets the controller redirect the same edge the PC rolls over.
    assign wrap = inc && !clr && !ld && (&pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (ld) begin
            pc <= ld_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - fetch/decode/execute sequencer for an external ALU; SEQ_CTRL_BRANCH_EN enables JZ/JC and the Z/C flags
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter bit HALT_ON_WRAP = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IR_W-1:0]   imem_data,
    output logic [3:0]        inst,
    output logic [7:0]        b,
    input  logic [8:0]        ans,
    output logic              d,
    output logic              busy,
    output logic              halted
);

    state_t            state, state_nx;
    logic [IR_W-1:0]   ir;
    logic [3:0]        op;
    logic              pc_clr, pc_ld, pc_inc, pc_wrap;
    logic [ADDR_W-1:0] pc;
    logic              branch_taken;
    logic              in_exwb;

    assign op = ir[11:8];

    seq_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .clr    (pc_clr),
        .ld     (pc_ld),
        .ld_val (ir[ADDR_W-1:0]),
        .inc    (pc_inc),
        .pc     (pc),
        .wrap   (pc_wrap)
    );

`ifdef SEQ_CTRL_BRANCH_EN
    logic z_q, c_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else if (state == WB) begin
            z_q <= (ans[7:0] == 8'd0);
            c_q <= ans[8];
        end
    end

    assign branch_taken = ((op == OP_JZ) && z_q) || ((op == OP_JC) && c_q);
`else
    logic unused_ans;
    assign unused_ans   = ^ans;
    assign branch_taken = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == DECODE) begin
                ir <= imem_data;
            end
        end
    end

    always_comb begin
        state_nx = state;
        pc_clr   = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nx = FETCH;
                    pc_clr   = 1'b1;
                end
            end
            FETCH:  state_nx = DECODE;
            DECODE: state_nx = EXEC;
            EXEC: begin
                state_nx = FETCH;
                if (is_alu(op)) begin
                    state_nx = WB;
                end else if (op == OP_HALT) begin
                    state_nx = HALTED;
                end else if (op == OP_JMP || branch_taken) begin
                    pc_ld = 1'b1;
                end else begin
                    // NOP, or a conditional branch falling through
                    pc_inc = 1'b1;
                end
            end
            WB: begin
                state_nx = FETCH;
                pc_inc   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (HALT_ON_WRAP && pc_wrap) begin
            state_nx = HALTED;
        end
    end

    assign in_exwb   = (state == EXEC) || (state == WB);
    assign inst      = in_exwb ? ir[11:8] : 4'd0;
    assign b         = in_exwb ? ir[7:0] : 8'd0;
    assign d         = (state == WB);
    assign busy      = (state != IDLE) && (state != HALTED);
    assign halted    = (state == HALTED);
    assign imem_addr = pc;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - scoreboard bench for seq_ctrl against an instruction-level reference model
module tb_seq_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] inst;
        logic [7:0] b;
        logic [7:0] addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  imem_addr;
    logic [11:0] imem_data;
    logic [3:0]  inst;
    logic [7:0]  b;
    logic [8:0]  ans;
    logic        d, busy, halted;

    logic        start2;
    logic [1:0]  imem_addr2;
    logic [3:0]  inst2;
    logic [7:0]  b2;
    logic        d2, busy2, halted2;

    logic [11:0] mem [256];
    ev_t         sb [$];
    ev_t         mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          go = 1'b0;
    bit          mz = 1'b0, mc = 1'b0;

    always #5 clk = ~clk;

    seq_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .inst      (inst),
        .b         (b),
        .ans       (ans),
        .d         (d),
        .busy      (busy),
        .halted    (halted)
    );

    seq_ctrl #(.ADDR_W(2), .HALT_ON_WRAP(1'b1)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .imem_addr (imem_addr2),
        .imem_data (12'hE00),
        .inst      (inst2),
        .b         (b2),
        .ans       (9'd0),
        .d         (d2),
        .busy      (busy2),
        .halted    (halted2)
    );

    // Behavioural ALU: result = literal + opcode, carry in bit 8.
    assign ans = {1'b0, b} + {5'd0, inst};

    always @(posedge clk) imem_data <= mem[imem_addr];

    always @(posedge clk) begin
        if (go) cyc = 1;
        else    cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_d: d=1 at cycle %0d addr %0d, expected no strobe", cyc, imem_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("d_cycle", cyc, mon_e.cyc);
                chk("d_inst", inst, mon_e.inst);
                chk("d_b", b, mon_e.b);
                chk("d_addr", imem_addr, mon_e.addr);
            end
        end
        if (d2 === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL d2_strobe: d2=1 on NOP-only program, expected 0");
        end
    end

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        go    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        go    = 1'b0;
    endtask

    task automatic do_reset(input string name);
        #2 reset = 1'b0;
        #1 chk(name, int'({d, busy, halted, inst, b, imem_addr}), 0);
        @(negedge clk);
        reset = 1'b1;
        mz = 1'b0;
        mc = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    endtask

    // Interprets the program one instruction at a time, queues every expected
    // write strobe with its cycle, then drives start and checks the end state.
    task automatic run_prog(input string name, input int max_instr, input bit spur);
        int  pc = 0;
        int  t = 1;
        bit  hlt = 1'b0;
        int  op, lit, a, spur_k;
        bit  taken;
        ev_t e;
        for (int n = 0; n < max_instr && !hlt; n++) begin
            op  = int'(mem[pc][11:8]);
            lit = int'(mem[pc][7:0]);
            if (op <= 10) begin
                e.cyc  = t + 3;
                e.inst = 4'(op);
                e.b    = 8'(lit);
                e.addr = 8'(pc);
                sb.push_back(e);
                a  = lit + op;
                mz = (a % 256) == 0;
                mc = a >= 256;
                pc = (pc + 1) % 256;
                t  = t + 4;
            end else begin
                case (op)
                    11: pc = lit;
                    12, 13: begin
                        taken = 1'b0;
`ifdef SEQ_CTRL_BRANCH_EN
                        taken = (op == 12) ? mz : mc;
`endif
                        pc = taken ? lit : (pc + 1) % 256;
                    end
                    14: pc = (pc + 1) % 256;
                    default: hlt = 1'b1;
                endcase
                t = t + 3;
            end
        end
        spur_k = $urandom_range(1, t - 1);
        start_pulse();
        for (int k = 1; k < t; k++) begin
            start = spur && (k == spur_k);
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_halted"}, halted, hlt);
        chk({name, "_busy"}, busy, !hlt);
        chk({name, "_addr"}, imem_addr, pc);
        chk({name, "_pending_d"}, sb.size(), 0);
        sb.delete();
        do_reset({name, "_rst"});
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        fill_halt();
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({d, busy, halted, inst, b, imem_addr}), 0);
        chk("reset_outs2", int'({d2, busy2, halted2, inst2, b2, imem_addr2}), 0);
        reset = 1'b1;

        // Four NOPs on a 2-bit PC: wrap in cycle 12 forces HALTED in cycle 13.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (11) @(negedge clk);
        chk("wrap2_not_yet", halted2, 0);
        @(negedge clk);
        chk("wrap2_halted", halted2, 1);
        chk("wrap2_addr", imem_addr2, 0);
        chk("wrap2_busy", busy2, 0);

        // Reset in WB aborts the strobe, then the block stays idle.
        mem[0] = 12'h0AB;
        mon_e.cyc = 4; mon_e.inst = 4'h0; mon_e.b = 8'hAB; mon_e.addr = 8'd0;
        sb.push_back(mon_e);
        start_pulse();
        repeat (3) @(negedge clk);
        chk("wb_d_high", d, 1);
        do_reset("wb_abort");
        repeat (3) @(negedge clk);
        chk("idle_after_abort", busy, 0);
        chk("abort_queue", sb.size(), 0);

        fill_halt();
        mem[0] = 12'h00A; mem[1] = 12'h103; mem[2] = 12'hF00;
        run_prog("prog_alu", 50, 1'b0);

        fill_halt();
        mem[0] = 12'hB05;
        for (int i = 1; i < 5; i++) mem[i] = 12'h0FF;
        run_prog("prog_jmp", 50, 1'b0);

        fill_halt();
        mem[0] = 12'h1FF; mem[1] = 12'hD07;
        run_prog("jc_set", 50, 1'b0);

        fill_halt();
        mem[0] = 12'h001; mem[1] = 12'hD07;
        run_prog("jc_clear", 50, 1'b0);

        fill_halt();
        mem[0] = 12'h000; mem[1] = 12'hC07;
        run_prog("jz_set", 50, 1'b0);

        fill_halt();
        mem[0] = 12'hBFF; mem[255] = 12'h0AB;
        run_prog("wrap8", 9, 1'b1);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 256; i++) begin
                int sel, lit;
                logic [3:0] op;
                sel = $urandom_range(0, 99);
                if (sel < 55)      op = 4'($urandom_range(0, 10));
                else if (sel < 65) op = 4'd11;
                else if (sel < 75) op = 4'($urandom_range(12, 13));
                else if (sel < 88) op = 4'd14;
                else               op = 4'd15;
                case ($urandom_range(0, 3))
                    0:       lit = 0;
                    1:       lit = 255;
                    2:       lit = 1;
                    default: lit = $urandom_range(0, 255);
                endcase
                mem[i] = {op, 8'(lit)};
            end
            run_prog("rand", 25, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
